// File: rtl/reg_dump_reader.sv
// Walks a register-file address range through one combinational read port and streams
// each word out MSB-first as bytes on a valid/ready link. `REG_DUMP_HEADER_EN adds a per-word header byte.
module reg_dump_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  adc_sck,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int BYTES = DATA_WIDTH / 8;
`ifdef REG_DUMP_HEADER_EN
  localparam int LAST_CNT = BYTES;
`else
  localparam int LAST_CNT = BYTES - 1;
`endif
  localparam int CW = $clog2(BYTES + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_cur, r_last;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CW-1:0]         r_cnt;
  logic                  w_hs, w_word_end, w_is_hdr, w_at_last;
  logic [7:0]            w_hdr;

  assign w_hs       = (r_state == S_SEND) && tx_ready;
  assign w_word_end = w_hs && (r_cnt == CW'(LAST_CNT));
  assign w_at_last  = (r_cur == r_last);
  assign w_hdr      = {3'b101, r_cur[4:0]};
`ifdef REG_DUMP_HEADER_EN
  assign w_is_hdr = (r_cnt == '0);
`else
  assign w_is_hdr = 1'b0;
`endif

  always_ff @(posedge adc_sck or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (first_addr > last_addr) ? S_DONE : S_FETCH;
      S_FETCH: w_next = S_SEND;
      S_SEND:  if (w_word_end) w_next = w_at_last ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_valid = (r_state == S_SEND);
    busy     = (r_state == S_FETCH) || (r_state == S_SEND);
    done     = (r_state == S_DONE);
    tx_data  = 8'h00;
    if (r_state == S_SEND) tx_data = w_is_hdr ? w_hdr : r_shift[DATA_WIDTH-1 -: 8];
  end

  // Address is only advanced after the last word check, so last_addr=max never wraps.
  always_ff @(posedge adc_sck or negedge reset) begin
    if (!reset) begin
      r_cur   <= '0;
      r_last  <= '0;
      rd_addr <= '0;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_cur   <= first_addr;
          r_last  <= last_addr;
          rd_addr <= first_addr;
        end
        S_FETCH: begin
          r_shift <= rd_data;
          r_cnt   <= '0;
        end
        S_SEND: if (w_hs) begin
          if (!w_is_hdr) r_shift <= r_shift << 8;
          r_cnt <= r_cnt + CW'(1);
          if (w_word_end && !w_at_last) begin
            r_cur   <= r_cur + ADDR_WIDTH'(1);
            rd_addr <= r_cur + ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed + randomized bench for reg_dump_reader against a byte-queue reference model.
module tb_reg_dump_reader;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef REG_DUMP_HEADER_EN
  localparam int XW = 5;
`else
  localparam int XW = 4;
`endif

  logic          adc_sck = 0;
  logic          reset = 0;
  logic          start = 0;
  logic [AW-1:0] first_addr = 0, last_addr = 0, rd_addr;
  logic [DW-1:0] rd_data;
  logic [7:0]    tx_data;
  logic          tx_valid, tx_ready = 0, busy, done;

  logic [31:0] regs [32];
  byte unsigned exp_q[$], got_q[$];
  int n_cmp = 0, n_bad = 0, done_cnt = 0;
  logic   r_stall = 0;
  logic [7:0] r_prev = 0;

  reg_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .adc_sck(adc_sck), .reset(reset), .start(start), .first_addr(first_addr),
    .last_addr(last_addr), .rd_addr(rd_addr), .rd_data(rd_data), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done));

  always #5 adc_sck = ~adc_sck;
  assign rd_data = (rd_addr == 0) ? 32'h0 : regs[rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte monitor: records handshakes, checks hold-while-stalled, counts done pulses.
  always @(negedge adc_sck) begin
    if (!reset) r_stall <= 0;
    else begin
      if (r_stall) begin
        chk("stall_valid", {31'b0, tx_valid}, 1);
        chk("stall_data", {24'b0, tx_data}, {24'b0, r_prev});
      end
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (done) done_cnt++;
      r_stall <= tx_valid && !tx_ready;
      r_prev  <= tx_data;
    end
  end

  task automatic cyc();
    @(posedge adc_sck); #1;
  endtask

  task automatic push_word(input int a, input logic [31:0] v);
`ifdef REG_DUMP_HEADER_EN
    exp_q.push_back({3'b101, a[4:0]});
`endif
    for (int k = 3; k >= 0; k--) exp_q.push_back(v[8*k +: 8]);
  endtask

  task automatic build_exp(input int f, input int l);
    for (int a = f; a <= l; a++) push_word(a, (a == 0) ? 32'h0 : regs[a]);
  endtask

  task automatic run_dump(input int f, input int l, input bit rnd, input bit poke);
    int n;
    got_q.delete(); done_cnt = 0;
    cyc(); start = 1; first_addr = AW'(f); last_addr = AW'(l);
    tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc(); start = 0; first_addr = ~first_addr; last_addr = ~last_addr;
    n = 0;
    while (!done && n < 3000) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = poke && (n == 3);
      cyc(); n++;
    end
    start = 0;
    chk("done_seen", {31'b0, done}, 1);
    chk("busy_in_done", {31'b0, busy}, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("idle_busy", {31'b0, busy}, 0);
      chk("idle_valid", {31'b0, tx_valid}, 0);
    end
    chk("done_count", done_cnt, 1);
    chk("byte_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("byte%0d", i), {24'b0, got_q[i]}, {24'b0, exp_q[i]});
    exp_q.delete();
  endtask

  initial begin
    int n;
    logic [31:0] old7;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'hFFFF_FFFF;
    regs[1] = 32'h1234_5678;
    #12;
    chk("rst_rd_addr", {27'b0, rd_addr}, 0);
    chk("rst_tx_data", {24'b0, tx_data}, 0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    reset = 1;

    // single word, exact latency
    build_exp(1, 1); got_q.delete(); done_cnt = 0;
    cyc(); start = 1; first_addr = 1; last_addr = 1; tx_ready = 1;
    cyc(); start = 0;
    chk("c1_busy", {31'b0, busy}, 1);
    chk("c1_valid", {31'b0, tx_valid}, 0);
    chk("c1_rd_addr", {27'b0, rd_addr}, 1);
    for (int k = 0; k < XW; k++) begin
      cyc();
      chk($sformatf("c%0d_valid", k + 2), {31'b0, tx_valid}, 1);
      chk($sformatf("c%0d_data", k + 2), {24'b0, tx_data}, {24'b0, exp_q[k]});
    end
    cyc();
    chk("cdone_done", {31'b0, done}, 1);
    chk("cdone_busy", {31'b0, busy}, 0);
    chk("cdone_valid", {31'b0, tx_valid}, 0);
    cyc();
    chk("cpost_done", {31'b0, done}, 0);
    chk("cpost_busy", {31'b0, busy}, 0);
    exp_q.delete();

    // 0..2 with x0 reading back as zero
    regs[1] = 32'h0; regs[2] = 32'hDEAD_BEEF;
    build_exp(0, 2); run_dump(0, 2, 0, 0);

    // random ready
    regs[1] = $urandom; regs[2] = $urandom;
    build_exp(0, 2); run_dump(0, 2, 1, 0);

    // empty range
    done_cnt = 0;
    cyc(); start = 1; first_addr = 5; last_addr = 3;
    cyc(); start = 0;
    chk("empty_done", {31'b0, done}, 1);
    chk("empty_valid", {31'b0, tx_valid}, 0);
    chk("empty_busy", {31'b0, busy}, 0);
    cyc();
    chk("empty_done_off", {31'b0, done}, 0);
    chk("empty_valid2", {31'b0, tx_valid}, 0);

    // reset mid-dump at byte 2 of register 4
    got_q.delete(); done_cnt = 0;
    cyc(); start = 1; first_addr = 0; last_addr = 31; tx_ready = 1;
    cyc(); start = 0;
    n = 0;
    while (got_q.size() < 4 * XW + XW - 2 && n < 200) begin cyc(); n++; end
    chk("mid_reached", got_q.size(), 4 * XW + XW - 2);
    chk("mid_valid", {31'b0, tx_valid}, 1);
    chk("mid_data", {24'b0, tx_data}, {24'b0, regs[4][15:8]});
    reset = 0; #1;
    chk("arst_rd_addr", {27'b0, rd_addr}, 0);
    chk("arst_tx_data", {24'b0, tx_data}, 0);
    chk("arst_tx_valid", {31'b0, tx_valid}, 0);
    chk("arst_busy", {31'b0, busy}, 0);
    chk("arst_done", {31'b0, done}, 0);
    cyc(); cyc(); reset = 1; cyc(); cyc();
    chk("arst_no_done", done_cnt, 0);
    chk("arst_idle", {31'b0, busy}, 0);

    // fresh dump with an ignored start while busy
    build_exp(3, 6); run_dump(3, 6, 1, 1);

    // top of range, no wrap
    regs[31] = 32'hCAFE_F00D;
    build_exp(31, 31); run_dump(31, 31, 0, 0);
    build_exp(29, 31); run_dump(29, 31, 1, 0);

    // snapshot: word 7 already loaded, word 8 not yet fetched
    old7 = regs[7];
    got_q.delete(); done_cnt = 0;
    cyc(); start = 1; first_addr = 7; last_addr = 9; tx_ready = 0;
    cyc(); start = 0;
    cyc();
    chk("snap_valid", {31'b0, tx_valid}, 1);
    regs[7] = ~old7; regs[8] = 32'hA5A5_0F0F;
    push_word(7, old7); build_exp(8, 9);
    n = 0;
    tx_ready = 1;
    while (!done && n < 200) begin cyc(); n++; end
    cyc(); cyc();
    chk("snap_done", done_cnt, 1);
    chk("snap_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("snap%0d", i), {24'b0, got_q[i]}, {24'b0, exp_q[i]});
    exp_q.delete();

    // random ranges
    for (int t = 0; t < 3; t++) begin
      int f, l;
      f = $urandom_range(0, 31); l = $urandom_range(f, (f + 4 > 31) ? 31 : f + 4);
      for (int i = 1; i < 32; i++) regs[i] = $urandom;
      build_exp(f, l); run_dump(f, l, 1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
